// File: rtl/frame_gen_pkg.sv
// frame_gen shared types: FSM states, metadata layout
// and the self-checking word pattern.
package frame_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    META,
    DATA
  } state_e;

  localparam int MD_IDX   = 0;
  localparam int MD_SIZE  = 1;
  localparam int MD_BEATS = 2;

  localparam int IDX_W  = 8;
  localparam int WORD_W = 24;

  function automatic logic [31:0] pat_word(
    input logic [IDX_W-1:0]  idx,
    input logic [WORD_W-1:0] w
  );
    return {idx, w};
  endfunction

endpackage

// File: rtl/frame_gen_if.sv
// AXI-Stream bundle used for both the metadata
// and the frame-data outputs of frame_gen.
interface frame_gen_if #(
  parameter int DW = 512
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic            tvalid;
  logic            tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/frame_gen_keep_mask.sv
// Final-beat byte enables from the frame-size
// remainder; zero remainder means a full beat.
module keep_mask
  import frame_gen_pkg::*;
#(
  parameter int BPB = 64
) (
  input  logic [$clog2(BPB)-1:0] rem_i,
  output logic [BPB-1:0]         mask_o
);

  always_comb begin
    mask_o = '1;
    if (rem_i != '0)
      mask_o = (BPB'(1) << rem_i) - BPB'(1);
  end

endmodule

// File: rtl/frame_gen.sv
// Synthetic frame source: metadata beat then a
// patterned data frame, repeated per frame count.
module frame_gen
  import frame_gen_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] frames_to_generate,
  input  logic [31:0] frame_size,
  output logic        idle,
  frame_gen_if.master axis_md,
  frame_gen_if.master axis_df
);

  localparam int BPB = DW / 8;
  localparam int NW  = DW / 32;
  localparam int RW  = $clog2(BPB);
  localparam logic [31:0] BPB32 = 32'(BPB);
  localparam logic [31:0] NW32  = 32'(NW);

  state_e state_q, state_d;
  logic [31:0] left_q, left_d;
  logic [31:0] fsize_q, fsize_d;
  logic [31:0] beats_q, beats_d;
  logic [31:0] beat_q, beat_d;
  logic [31:0] idx_q, idx_d;
  logic          md_valid_q, md_valid_d;
  logic [DW-1:0] md_data_q, md_data_d;
  logic           df_valid_q, df_valid_d;
  logic           df_last_q, df_last_d;
  logic [DW-1:0]  df_data_q, df_data_d;
  logic [BPB-1:0] df_keep_q, df_keep_d;

  logic [31:0]    start_beats;
  logic [31:0]    nxt_beat;
  logic [RW-1:0]  rem;
  logic [BPB-1:0] tail_mask;
  logic           first_last;
  logic           nxt_last;

  function automatic logic [DW-1:0] mk_md(
    input logic [31:0] idx,
    input logic [31:0] size,
    input logic [31:0] beats
  );
    logic [DW-1:0] d;
    d = '0;
    d[MD_IDX*32   +: 32] = idx;
    d[MD_SIZE*32  +: 32] = size;
    d[MD_BEATS*32 +: 32] = beats;
    return d;
  endfunction

  function automatic logic [DW-1:0] mk_beat(
    input logic [31:0] idx,
    input logic [31:0] b
  );
    logic [DW-1:0] d;
    d = '0;
    for (int j = 0; j < NW; j++)
      d[j*32 +: 32] = pat_word(idx[IDX_W-1:0],
        WORD_W'(b * NW32 + 32'(j)));
    return d;
  endfunction

  // Division form avoids overflow of fsize+BPB-1.
  assign start_beats = frame_size / BPB32
    + 32'((frame_size % BPB32) != 0);
  assign rem        = RW'(fsize_q % BPB32);
  assign nxt_beat   = beat_q + 32'd1;
  assign first_last = (beats_q == 32'd1);
  assign nxt_last   = (nxt_beat == beats_q - 32'd1);

  keep_mask #(
    .BPB(BPB)
  ) u_keep (
    .rem_i (rem),
    .mask_o(tail_mask)
  );

  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    fsize_d    = fsize_q;
    beats_d    = beats_q;
    beat_d     = beat_q;
    idx_d      = idx_q;
    md_valid_d = md_valid_q;
    md_data_d  = md_data_q;
    df_valid_d = df_valid_q;
    df_last_d  = df_last_q;
    df_data_d  = df_data_q;
    df_keep_d  = df_keep_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start && frames_to_generate != '0
            && frame_size != '0) begin
          left_d     = frames_to_generate;
          fsize_d    = frame_size;
          beats_d    = start_beats;
          idx_d      = '0;
          md_valid_d = 1'b1;
          md_data_d  = mk_md('0, frame_size,
                             start_beats);
          state_d    = META;
        end
      end
      (state_q == META): begin
        if (axis_md.tready) begin
          md_valid_d = 1'b0;
          beat_d     = '0;
          df_valid_d = 1'b1;
          df_data_d  = mk_beat(idx_q, '0);
          df_last_d  = first_last;
          df_keep_d  = first_last ? tail_mask : '1;
          state_d    = DATA;
        end
      end
      (state_q == DATA): begin
        if (axis_df.tready) begin
          if (df_last_q) begin
            df_valid_d = 1'b0;
            df_last_d  = 1'b0;
            left_d     = left_q - 32'd1;
            idx_d      = idx_q + 32'd1;
            if (left_q == 32'd1) begin
              state_d = IDLE;
            end else begin
              md_valid_d = 1'b1;
              md_data_d  = mk_md(idx_q + 32'd1,
                                 fsize_q, beats_q);
              state_d    = META;
            end
          end else begin
            beat_d    = nxt_beat;
            df_data_d = mk_beat(idx_q, nxt_beat);
            df_last_d = nxt_last;
            df_keep_d = nxt_last ? tail_mask : '1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      left_q     <= '0;
      fsize_q    <= '0;
      beats_q    <= '0;
      beat_q     <= '0;
      idx_q      <= '0;
      md_valid_q <= 1'b0;
      md_data_q  <= '0;
      df_valid_q <= 1'b0;
      df_last_q  <= 1'b0;
      df_data_q  <= '0;
      df_keep_q  <= '0;
    end else begin
      state_q    <= state_d;
      left_q     <= left_d;
      fsize_q    <= fsize_d;
      beats_q    <= beats_d;
      beat_q     <= beat_d;
      idx_q      <= idx_d;
      md_valid_q <= md_valid_d;
      md_data_q  <= md_data_d;
      df_valid_q <= df_valid_d;
      df_last_q  <= df_last_d;
      df_data_q  <= df_data_d;
      df_keep_q  <= df_keep_d;
    end
  end

  assign idle = (state_q == IDLE) && !start;

  assign axis_md.tdata  = md_data_q;
  assign axis_md.tkeep  = '0;
  assign axis_md.tlast  = 1'b0;
  assign axis_md.tvalid = md_valid_q;

  assign axis_df.tdata  = df_data_q;
  assign axis_df.tkeep  = df_keep_q;
  assign axis_df.tlast  = df_last_q;
  assign axis_df.tvalid = df_valid_q;

endmodule
